tiny_riscv_gpio: RTL and testbench
==================================

# tiny_riscv_gpio

Parametrised memory-mapped GPIO peripheral for the tiny_riscv SoC. It replaces the fixed 4-bit LED/switch wiring in tiny_riscv_top with configurable-width LED outputs and switch inputs. Switches pass through a synchroniser and a per-bit debouncer, and a level interrupt reports switch changes. The block sits on the processor data bus next to RAM and is the only path from the core to the board LEDs and switches.

## Interface
- LED_WIDTH, 4, number of LED outputs (1..32)
- SWITCH_WIDTH, 4, number of switch inputs (1..32)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a switch change (>=1)
- RESET_LED, 0, o_LED value after reset (LED_WIDTH bits)

- i_Clk  in  1  system clock; all flops rise-edge
- i_Rst_N  in  1  asynchronous active-low reset
- i_Sel  in  1  bus request
- i_We  in  1  1 = write, 0 = read; sampled with i_Sel
- i_Addr  in  4  byte address; bits [3:2] select register, bits [1:0] ignored
- i_WData  in  32  write data
- o_RData  out  32  registered read data; zero-extended
- o_Ready  out  1  one-cycle completion pulse
- o_LED  out  LED_WIDTH  LED drive
- i_Switch  in  SWITCH_WIDTH  raw asynchronous switch inputs
- o_Irq  out  1  level interrupt = |(PEND & EN)

## Operation
- Register map, word offsets:
  - 0x0 OUT (RW): drives o_LED. Writes take i_WData[LED_WIDTH-1:0].
  - 0x4 IN (RO): debounced switch value. Writes are ignored.
  - 0x8 EN (RW): per-switch interrupt enable, SWITCH_WIDTH bits.
  - 0xC PEND (W1C): per-switch change flags. Writing 1 clears a bit; writing 0 leaves it unchanged.
- Register bits above the field width read 0. Byte enables are not supported.
- Synchroniser: two flops per switch bit (sync1, sync2). Reset value is 0.
- Debouncer, one counter per bit, width $clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == deb: cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: deb <= sync2, cnt <= 0, PEND[i] <= 1.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches deb.
- PEND is set on every accepted change, rising or falling, whether or not EN is set. EN only gates o_Irq.
- Simultaneous PEND set and W1C clear of the same bit in the same cycle: the set wins and the bit stays 1.
- Bus transaction:
  - A request is accepted on an edge where i_Sel=1 and o_Ready=0.
  - A write updates the target register on that edge.
  - A read captures the register into o_RData on that edge.
  - o_Ready=1 on the following cycle.
  - A held i_Sel therefore completes a transaction every second cycle. o_RData holds its value until the next accepted read.
- Reset values: o_LED=RESET_LED, o_RData=0, o_Ready=0, o_Irq=0, EN=0, PEND=0, deb=0, cnt=0, sync=0.
- Reset asserted mid-debounce or mid-transaction aborts it immediately. No o_Ready is issued for the aborted transaction.
- Switches held high through reset are accepted after reset release as a normal change. They set PEND, but o_Irq stays 0 because EN=0.

## Timing
- Write-to-LED: o_LED changes on the accepting edge. This is the same edge o_Ready rises for.
- Read latency: o_RData is valid together with o_Ready, one cycle after acceptance.
- Switch latency:
  - A change sampled by sync1 at edge N reaches sync2 at edge N+1.
  - deb updates at edge N+1+DEBOUNCE_CYCLES, and PEND is set on the same edge.
  - o_Irq follows PEND/EN combinationally from flops, so it is visible in the same cycle as PEND.
- EN write affects o_Irq from the accepting edge onward. A PEND clear likewise deasserts o_Irq from the accepting edge onward.
- No combinational path from bus inputs to o_RData or o_Ready.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LED_WIDTH=SWITCH_WIDTH=4 unless stated otherwise.
- Reset: hold i_Rst_N=0 with RESET_LED=4'b1010 -> o_LED=1010, o_Ready=0, o_Irq=0, o_RData=0. Release, read 0x8 and 0xC -> both 0.
- LED write/read-back: write 0x0 = 0xFFFF_FFF5 -> o_LED=0101 on the accepting edge, o_Ready pulses one cycle later. Read 0x0 -> o_RData=0x0000_0005.
- Debounce:
  - i_Switch[0] high for 3 cycles, then low -> IN stays 0 and PEND stays 0.
  - Held high -> IN=0x1 exactly 5 edges after the sync1 sample, and PEND=0x1.
- Interrupt:
  - Write EN=0x1, toggle switch 0 stably -> o_Irq=1.
  - Write PEND=0x2 -> o_Irq stays 1.
  - Write PEND=0x1 -> o_Irq=0 from the accepting edge.
- Collision: arrange a debounce acceptance on bit 1 on the same edge as a W1C of bit 1 -> PEND[1]=1 afterwards.
- Reset mid-operation: assert i_Rst_N=0 with cnt=2 and a read pending -> no o_Ready. After release, sync, cnt, PEND and o_RData are all 0.

Source files
------------

// File: rtl/tiny_riscv_gpio_if.sv
// Data-bus port of the tiny_riscv GPIO peripheral.
// The core asserts i_Sel with i_We/i_Addr/i_WData; the peripheral accepts on a rising edge where
// i_Sel=1 and o_Ready=0, and pulses o_Ready for one cycle afterwards (o_RData valid with it).
interface tiny_riscv_gpio_if;
    logic        i_Sel;
    logic        i_We;
    logic [3:0]  i_Addr;
    logic [31:0] i_WData;
    logic [31:0] o_RData;
    logic        o_Ready;

    modport master (
        output i_Sel, i_We, i_Addr, i_WData,
        input  o_RData, o_Ready
    );

    modport slave (
        input  i_Sel, i_We, i_Addr, i_WData,
        output o_RData, o_Ready
    );
endinterface

// File: rtl/tiny_riscv_gpio.sv
// Memory-mapped GPIO: LED output register, synchronised and debounced switch inputs,
// per-switch change flags (W1C) and a level interrupt gated by an enable mask.
module tiny_riscv_gpio #(
    parameter int                   LED_WIDTH       = 4,
    parameter int                   SWITCH_WIDTH    = 4,
    parameter int                   DEBOUNCE_CYCLES = 16,
    parameter logic [LED_WIDTH-1:0] RESET_LED       = '0
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_N,
    tiny_riscv_gpio_if.slave        bus,
    output logic [LED_WIDTH-1:0]    o_LED,
    input  logic [SWITCH_WIDTH-1:0] i_Switch,
    output logic                    o_Irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_EN   = 2'd2;
    localparam logic [1:0] REG_PEND = 2'd3;

    logic [SWITCH_WIDTH-1:0] sync1;
    logic [SWITCH_WIDTH-1:0] sync2;
    logic [SWITCH_WIDTH-1:0] deb;
    logic [SWITCH_WIDTH-1:0] en;
    logic [SWITCH_WIDTH-1:0] pend;
    logic [SWITCH_WIDTH-1:0] deb_hit;
    logic [SWITCH_WIDTH-1:0] pend_clr;
    logic [CNT_W-1:0]        cnt [SWITCH_WIDTH];

    logic        accept;
    logic        wr_en;
    logic [1:0]  reg_sel;
    logic [31:0] rd_mux;
    logic        unused_bits;

    // Byte-lane address bits and write data above the field widths carry no meaning here.
    assign unused_bits = ^{bus.i_Addr[1:0], bus.i_WData};

    assign accept  = bus.i_Sel & ~bus.o_Ready;
    assign wr_en   = accept & bus.i_We;
    assign reg_sel = bus.i_Addr[3:2];

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_Switch;
            sync2 <= sync1;
        end
    end

    // A bit is accepted once sync2 has differed from deb for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        deb_hit = '0;
        for (int i = 0; i < SWITCH_WIDTH; i++) begin
            deb_hit[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            deb <= '0;
            for (int i = 0; i < SWITCH_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SWITCH_WIDTH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (deb_hit[i]) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        pend_clr = '0;
        if (wr_en && reg_sel == REG_PEND) begin
            pend_clr = bus.i_WData[SWITCH_WIDTH-1:0];
        end
    end

    // A fresh acceptance overrides a same-cycle W1C so no change is ever lost.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | deb_hit;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_OUT:  rd_mux = 32'(o_LED);
            REG_IN:   rd_mux = 32'(deb);
            REG_EN:   rd_mux = 32'(en);
            REG_PEND: rd_mux = 32'(pend);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            o_LED       <= RESET_LED;
            en          <= '0;
            bus.o_Ready <= 1'b0;
            bus.o_RData <= '0;
        end else begin
            bus.o_Ready <= accept;
            if (wr_en) begin
                case (reg_sel)
                    REG_OUT: o_LED <= bus.i_WData[LED_WIDTH-1:0];
                    REG_EN:  en    <= bus.i_WData[SWITCH_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (accept && !bus.i_We) begin
                bus.o_RData <= rd_mux;
            end
        end
    end

    assign o_Irq = |(pend & en);

endmodule

// File: tb/tb_tiny_riscv_gpio.sv
// Directed bench for tiny_riscv_gpio with DEBOUNCE_CYCLES=4 and 4-bit LED/switch fields.
module tb_tiny_riscv_gpio;
  localparam int LW = 4;
  localparam int SW = 4;
  localparam int DC = 4;
  localparam logic [LW-1:0] RL = 4'b1010;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [SW-1:0] sw = '0;
  logic [LW-1:0] led;
  logic irq;

  always #5 clk = ~clk;

  tiny_riscv_gpio_if bus();

  tiny_riscv_gpio #(
    .LED_WIDTH(LW),
    .SWITCH_WIDTH(SW),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LED(RL)
  ) dut (
    .i_Clk(clk),
    .i_Rst_N(rst_n),
    .bus(bus),
    .o_LED(led),
    .i_Switch(sw),
    .o_Irq(irq)
  );

  // scoreboard: {is_read, expected read data} per issued transaction
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (bus.o_Ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_ready: got o_Ready=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        if (e[32]) check("read_data", bus.o_RData, e[31:0]);
      end
    end
  end

  // driver tasks: call away from a rising edge with o_Ready low
  task automatic bus_issue(input logic we, input logic [3:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
    exp_q.push_back({~we, (we ? 32'h0 : exp_rd)});
    bus.i_Sel = 1'b1;
    bus.i_We = we;
    bus.i_Addr = addr;
    bus.i_WData = wdata;
    @(posedge clk);
    #1;
    bus.i_Sel = 1'b0;
    bus.i_We = 1'b0;
  endtask

  task automatic bus_finish();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata);
    bus_issue(1'b1, addr, wdata, 32'h0);
    bus_finish();
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp_rd);
    bus_issue(1'b0, addr, 32'h0, exp_rd);
    bus_finish();
  endtask

  initial begin
    bus.i_Sel = 1'b0;
    bus.i_We = 1'b0;
    bus.i_Addr = '0;
    bus.i_WData = '0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_led", 32'(led), 32'(RL));
    check("reset_ready", 32'(bus.o_Ready), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rdata", bus.o_RData, 32'h0);
    rst_n = 1'b1;
    bus_read(4'h8, 32'h0);
    bus_read(4'hC, 32'h0);

    // LED write lands on the accepting edge, read-back is zero-extended
    bus_issue(1'b1, 4'h0, 32'hFFFF_FFF5, 32'h0);
    check("led_on_accept", 32'(led), 32'h5);
    bus_finish();
    bus_read(4'h0, 32'h0000_0005);

    // three-cycle glitch on switch 0 is rejected
    @(negedge clk);
    sw[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sw[0] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus_read(4'h4, 32'h0);
    bus_read(4'hC, 32'h0);

    // held switch accepted exactly 5 edges after the sync1 sample
    bus_write(4'h8, 32'h1);
    check("irq_idle", 32'(irq), 32'h0);
    @(negedge clk);
    sw[0] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("irq_before_accept", 32'(irq), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("irq_at_accept", 32'(irq), 32'h1);
    bus_read(4'h4, 32'h1);
    bus_read(4'hC, 32'h1);

    // interrupt clear, falling change, W1C of another bit, W1C of the live bit
    bus_issue(1'b1, 4'hC, 32'h1, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_finish();
    @(negedge clk);
    sw[0] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("irq_on_fall", 32'(irq), 32'h1);
    bus_issue(1'b1, 4'hC, 32'h2, 32'h0);
    check("irq_other_w1c", 32'(irq), 32'h1);
    bus_finish();
    bus_issue(1'b1, 4'hC, 32'h1, 32'h0);
    check("irq_w1c_accept_edge", 32'(irq), 32'h0);
    bus_finish();

    // acceptance on bit 1 collides with W1C of bit 1: set wins
    @(negedge clk);
    sw[1] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus_write(4'hC, 32'h2);
    bus_read(4'hC, 32'h2);
    bus_read(4'h4, 32'h2);
    bus_write(4'h8, 32'h3);
    check("irq_bit1", 32'(irq), 32'h1);

    // reset with cnt[2]=2 and a read accepted but not yet completed
    @(negedge clk);
    sw[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.i_Sel = 1'b1;
    bus.i_We = 1'b0;
    bus.i_Addr = 4'h4;
    @(posedge clk);
    #1;
    bus.i_Sel = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.o_Ready), 32'h0);
    check("abort_rdata", bus.o_RData, 32'h0);
    check("abort_led", 32'(led), 32'(RL));
    check("abort_irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // switches 1 and 2 held through reset are re-accepted from scratch
    bus_write(4'h8, 32'h4);
    check("rdata_after_release", bus.o_RData, 32'h0);
    check("irq_after_release", 32'(irq), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("irq_before_reaccept", 32'(irq), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("irq_at_reaccept", 32'(irq), 32'h1);
    bus_read(4'hC, 32'h6);
    bus_read(4'h4, 32'h6);
    bus_read(4'h8, 32'h4);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
